mem_port_arbiter: RTL

Arbitrates the single shared instruction/data memory port between the multicycle CPU (requester 0) and a debug/DMA loader (requester 1). Accepts one transaction at a time and sequences issue, fixed-latency wait and completion. Returns read data and a one-cycle acknowledge to the winning requester. Sits between the CPU datapath's Adr/WriteData/ReadData path and the memory macro.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory port: CPU (0) and debug/DMA loader (1).
// Define MEMARB_FIXED_PRIO_EN to make the CPU always win ties (default: round-robin).
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    output logic          ack0,
    output logic [DW-1:0] rd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          ack1,
    output logic [DW-1:0] rd1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cur_we;
    logic          any_req;
    logic          win;

    // Winner selection for the IDLE grant
    always_comb begin
        any_req = req0 | req1;
`ifdef MEMARB_FIXED_PRIO_EN
        win = ~req0;
`else
        win = (req0 && req1) ? ~owner : req1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_we  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            mem_adr <= '0;
            mem_wd  <= '0;
            busy    <= 1'b0;
            owner   <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= win;
                        cur_we  <= win ? we1 : we0;
                        mem_we  <= win ? we1 : we0;
                        mem_adr <= win ? adr1 : adr0;
                        mem_wd  <= win ? wd1 : wd0;
                        mem_en  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= CW'(MEM_LAT - 1);
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // mem_rd is valid exactly MEM_LAT cycles after ISSUE
                        if (!cur_we) begin
                            if (owner) rd1 <= mem_rd;
                            else       rd0 <= mem_rd;
                        end
                        if (owner) ack1 <= 1'b1;
                        else       ack0 <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
